// File: rtl/multi_channel_memory.sv
// Shared word memory serving NUM_CH requesters through a round-robin arbiter
// and a fixed-latency, non-stalling response pipeline.
module multi_channel_memory #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          reqValid,
  output logic [NUM_CH-1:0]          reqReady,
  input  logic [NUM_CH*ADDR_W-1:0]   reqAddress,
  input  logic [NUM_CH*DATA_W-1:0]   reqDataIn,
  input  logic [NUM_CH-1:0]          reqWen,
  output logic [NUM_CH-1:0]          respValid,
  output logic [NUM_CH*DATA_W-1:0]   respDataOut,
  output logic [NUM_CH-1:0]          respError
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int HI_SH = OFF_W + $clog2(DEPTH_WORDS);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0]   NCH_L  = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0] LAST_L = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] grant_s;
  logic [CH_W-1:0]   gidx_s;
  logic [CH_W-1:0]   rr_q;
  logic [CH_W-1:0]   rr_d;
  logic              xfer_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              wen_s;
  logic              in_range_s;
  logic [IDX_W-1:0]  idx_s;
  logic              wr_s;
  logic              rd_s;

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] dat_q [LATENCY];
  logic              vld_q [LATENCY];
  logic [CH_W-1:0]   id_q  [LATENCY];
  logic              err_q [LATENCY];

  // Round-robin search starting at rr_q; first asserted valid wins.
  always_comb begin
    logic          found;
    logic [CH_W:0] sum;
    logic [CH_W:0] cand;
    logic          take;
    grant_s = '0;
    gidx_s  = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    take    = 1'b0;
    for (int o = 0; o < NUM_CH; o++) begin
      sum  = {1'b0, rr_q} + (CH_W + 1)'(o);
      cand = (sum >= NCH_L) ? (sum - NCH_L) : sum;
      take = !found && reqValid[cand[CH_W-1:0]];
      grant_s[cand[CH_W-1:0]] = grant_s[cand[CH_W-1:0]] | take;
      gidx_s = take ? cand[CH_W-1:0] : gidx_s;
      found  = found | take;
    end
  end

  assign reqReady = grant_s;
  assign xfer_s   = |grant_s;

  // Pointer moves past the winner only when a transfer actually happens.
  always_comb begin
    rr_d = rr_q;
    if (xfer_s) begin
      rr_d = (gidx_s == LAST_L) ? '0 : gidx_s + CH_W'(1);
    end else begin
      rr_d = rr_q;
    end
  end

  // Selected request fields and address decode.
  always_comb begin
    addr_s     = reqAddress[gidx_s * ADDR_W +: ADDR_W];
    wdata_s    = reqDataIn[gidx_s * DATA_W +: DATA_W];
    wen_s      = reqWen[gidx_s];
    // Any address bit above the word index makes the request out of range.
    in_range_s = ((addr_s >> HI_SH) == '0);
    idx_s      = addr_s[OFF_W +: IDX_W];
    wr_s       = xfer_s & wen_s & in_range_s;
    rd_s       = xfer_s & ~wen_s & in_range_s;
  end

  // Array write port, read sampling and data pipeline; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && wr_s) begin
      mem_q[idx_s] <= wdata_s;
    end
    dat_q[0] <= rd_s ? mem_q[idx_s] : '0;
    for (int k = 1; k < LATENCY; k++) begin
      dat_q[k] <= dat_q[k-1];
    end
  end

  // Control pipeline and arbiter pointer; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        vld_q[k] <= 1'b0;
        id_q[k]  <= '0;
        err_q[k] <= 1'b0;
      end
    end else begin
      rr_q     <= rr_d;
      vld_q[0] <= xfer_s;
      id_q[0]  <= gidx_s;
      err_q[0] <= xfer_s & ~in_range_s;
      for (int k = 1; k < LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
        err_q[k] <= err_q[k-1];
      end
    end
  end

  // Route the final stage to its channel; idle channels see all zeros.
  always_comb begin
    respValid   = '0;
    respDataOut = '0;
    respError   = '0;
    if (vld_q[LATENCY-1]) begin
      respValid[id_q[LATENCY-1]]                      = 1'b1;
      respDataOut[id_q[LATENCY-1] * DATA_W +: DATA_W] = dat_q[LATENCY-1];
      respError[id_q[LATENCY-1]]                      = err_q[LATENCY-1];
    end else begin
      respValid = '0;
    end
  end

endmodule

// File: tb/tb_multi_channel_memory.sv
// Bench for multi_channel_memory: a 2-channel LATENCY=4 instance and a
// 4-channel LATENCY=1 instance, checked against a transaction-level model.
module tb_multi_channel_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a = 1'b0;
  logic         rst_b = 1'b0;
  logic [3:0]   a_valid = 4'h0, a_wen = 4'h0;
  logic [127:0] a_addr = 128'h0, a_wdata = 128'h0;
  logic [1:0]   a_ready, a_rvalid, a_rerr;
  logic [63:0]  a_rdata;
  logic [3:0]   b_valid = 4'h0, b_wen = 4'h0;
  logic [127:0] b_addr = 128'h0, b_wdata = 128'h0;
  logic [3:0]   b_ready, b_rvalid, b_rerr;
  logic [127:0] b_rdata;

  multi_channel_memory #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(4)) dut_a (
    .clk(clk), .rst(rst_a),
    .reqValid(a_valid[1:0]), .reqReady(a_ready),
    .reqAddress(a_addr[63:0]), .reqDataIn(a_wdata[63:0]), .reqWen(a_wen[1:0]),
    .respValid(a_rvalid), .respDataOut(a_rdata), .respError(a_rerr)
  );

  multi_channel_memory #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst_b),
    .reqValid(b_valid), .reqReady(b_ready),
    .reqAddress(b_addr), .reqDataIn(b_wdata), .reqWen(b_wen),
    .respValid(b_rvalid), .respDataOut(b_rdata), .respError(b_rerr)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rr [2];
  logic [31:0] mm [int];
  logic        ev  [2][256];
  int          ech [2][256];
  logic [31:0] ed  [2][256];
  logic        ee  [2][256];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr, input int n);
    int c;
    for (int o = 0; o < n; o++) begin
      c = (ptr + o) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Model: at each falling edge, check this cycle's outputs, then schedule what
  // the next rising edge accepts (inputs are already stable for that edge).
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int n = 0; n < 2; n++) begin
        logic         rn, inr;
        logic [3:0]   vv, ww, ract, vact, eact, vexp, eexp;
        logic [127:0] adv, wdv, dact, dexp;
        logic [31:0]  ad;
        int g, nc, lt, s, due, key;
        nc   = (n == 0) ? 2 : 4;
        lt   = (n == 0) ? 4 : 1;
        rn   = (n == 0) ? rst_a : rst_b;
        vv   = (n == 0) ? {2'b00, a_valid[1:0]} : b_valid;
        ww   = (n == 0) ? a_wen : b_wen;
        adv  = (n == 0) ? {64'h0, a_addr[63:0]} : b_addr;
        wdv  = (n == 0) ? {64'h0, a_wdata[63:0]} : b_wdata;
        ract = (n == 0) ? {2'b00, a_ready} : b_ready;
        vact = (n == 0) ? {2'b00, a_rvalid} : b_rvalid;
        eact = (n == 0) ? {2'b00, a_rerr} : b_rerr;
        dact = (n == 0) ? {64'h0, a_rdata} : b_rdata;
        if (!rn) begin
          for (int i = 0; i < 256; i++) ev[n][i] = 1'b0;
          rr[n] = 0;
        end
        g = pick(vv, rr[n], nc);
        vexp = 4'h0;
        if (g >= 0) vexp[g] = 1'b1;
        chk($sformatf("ready[%0d]@%0d", n, cyc), {124'h0, ract}, {124'h0, vexp});
        s = cyc % 256;
        vexp = 4'h0;
        eexp = 4'h0;
        dexp = 128'h0;
        if (ev[n][s]) begin
          vexp[ech[n][s]] = 1'b1;
          eexp[ech[n][s]] = ee[n][s];
          dexp[ech[n][s]*32 +: 32] = ed[n][s];
        end
        ev[n][s] = 1'b0;
        chk($sformatf("resp_valid[%0d]@%0d", n, cyc), {124'h0, vact}, {124'h0, vexp});
        chk($sformatf("resp_err[%0d]@%0d", n, cyc), {124'h0, eact}, {124'h0, eexp});
        chk($sformatf("resp_data[%0d]@%0d", n, cyc), dact, dexp);
        if (rn && g >= 0) begin
          ad  = adv[g*32 +: 32];
          inr = (ad < 32'h1000);
          key = n * 2048 + int'(ad >> 2);
          due = (cyc + lt) % 256;
          ev[n][due]  = 1'b1;
          ech[n][due] = g;
          ee[n][due]  = !inr;
          ed[n][due]  = (inr && !ww[g]) ? mm[key] : 32'h0;
          if (inr && ww[g]) mm[key] = wdv[g*32 +: 32];
          rr[n] = (g + 1) % nc;
        end
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // Write then read of 0x40 on channel 0.
    a_valid[0] = 1'b1; a_wen[0] = 1'b1; a_addr[31:0] = 32'h40; a_wdata[31:0] = 32'hDEADBEEF;
    tick();
    a_wen[0] = 1'b0;
    tick();
    a_valid[0] = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t1_wack_valid", {126'h0, a_rvalid}, 128'h1);
    chk("t1_wack_data", {64'h0, a_rdata}, 128'h0);
    chk("t1_wack_err", {126'h0, a_rerr}, 128'h0);
    @(negedge clk);
    chk("t1_read_valid", {126'h0, a_rvalid}, 128'h1);
    chk("t1_read_data", {96'h0, a_rdata[31:0]}, 128'hDEADBEEF);

    // Preload 1..4, then four back-to-back reads.
    tick();
    a_valid[0] = 1'b1; a_wen[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_addr[31:0] = 32'(i * 4); a_wdata[31:0] = 32'(i + 1);
      tick();
    end
    a_wen[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_addr[31:0] = 32'(i * 4);
      tick();
    end
    a_valid[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("t2_pipe_data%0d", j), {96'h0, a_rdata[31:0]}, 128'(j + 1));
    end

    // Out-of-range write and read on channel 1, then read of word 0.
    tick();
    a_valid[1] = 1'b1; a_wen[1] = 1'b1; a_addr[63:32] = 32'h1000; a_wdata[63:32] = 32'h55;
    tick();
    a_wen[1] = 1'b0;
    tick();
    a_addr[63:32] = 32'h0;
    tick();
    a_valid[1] = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_oor_w_valid", {126'h0, a_rvalid}, 128'h2);
    chk("t3_oor_w_err", {126'h0, a_rerr}, 128'h2);
    chk("t3_oor_w_data", {64'h0, a_rdata}, 128'h0);
    @(negedge clk);
    chk("t3_oor_r_err", {126'h0, a_rerr}, 128'h2);
    chk("t3_oor_r_data", {64'h0, a_rdata}, 128'h0);
    @(negedge clk);
    chk("t3_word0_err", {126'h0, a_rerr}, 128'h0);
    chk("t3_word0_data", {96'h0, a_rdata[63:32]}, 128'h1);

    // Three reads in flight, then a one-cycle reset.
    tick();
    a_valid[0] = 1'b1; a_addr[31:0] = 32'h4;
    tick();
    a_addr[31:0] = 32'h8;
    tick();
    a_addr[31:0] = 32'hC;
    tick();
    a_valid[0] = 1'b0; rst_a = 1'b0;
    @(negedge clk);
    chk("t4_flush0", {126'h0, a_rvalid}, 128'h0);
    tick();
    rst_a = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk);
      chk($sformatf("t4_flush%0d", j), {126'h0, a_rvalid}, 128'h0);
    end

    // Both channels read continuously after reset: ch0 wins first.
    tick();
    a_valid[1:0] = 2'b11; a_wen = 4'h0; a_addr[31:0] = 32'h0; a_addr[63:32] = 32'h4;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("t5_grant%0d", j), {126'h0, a_ready}, (j % 2 == 0) ? 128'h1 : 128'h2);
      if (j == 4) begin
        chk("t5_resp_ch0", {126'h0, a_rvalid}, 128'h1);
        chk("t5_data_ch0", {96'h0, a_rdata[31:0]}, 128'h1);
      end
      if (j == 5) begin
        chk("t5_resp_ch1", {126'h0, a_rvalid}, 128'h2);
        chk("t5_data_ch1", {96'h0, a_rdata[63:32]}, 128'h2);
      end
      tick();
    end
    a_valid = 4'h0;
    repeat (6) tick();

    // Four channels, LATENCY=1: ch0 preloads 0x10, then ch1/ch3 contend.
    b_valid[0] = 1'b1; b_wen[0] = 1'b1; b_addr[31:0] = 32'h10; b_wdata[31:0] = 32'hA5A50000;
    tick();
    b_valid[0] = 1'b0;
    @(negedge clk);
    chk("b_wack_valid", {124'h0, b_rvalid}, 128'h1);
    chk("b_wack_data", b_rdata, 128'h0);
    tick();
    b_valid[1] = 1'b1; b_wen[1] = 1'b1; b_addr[63:32] = 32'h20; b_wdata[63:32] = 32'h77;
    b_valid[3] = 1'b1; b_wen[3] = 1'b0; b_addr[127:96] = 32'h10;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk($sformatf("b_grant%0d", j), {124'h0, b_ready}, (j % 2 == 0) ? 128'h2 : 128'h8);
      if (j >= 1) begin
        chk($sformatf("b_resp%0d", j), {124'h0, b_rvalid}, (j % 2 == 1) ? 128'h2 : 128'h8);
        chk($sformatf("b_data%0d", j), {96'h0, b_rdata[127:96]}, (j % 2 == 1) ? 128'h0 : 128'hA5A50000);
      end
      tick();
    end
    b_valid = 4'h0;
    tick();
    b_valid[3] = 1'b1; b_addr[127:96] = 32'h20;
    tick();
    b_valid = 4'h0;
    @(negedge clk);
    chk("b_read20_valid", {124'h0, b_rvalid}, 128'h8);
    chk("b_read20_data", {96'h0, b_rdata[127:96]}, 128'h77);
    tick();
    b_valid[2] = 1'b1; b_wen[2] = 1'b0; b_addr[95:64] = 32'h80000040;
    tick();
    b_valid = 4'h0;
    @(negedge clk);
    chk("b_hi_addr_err", {124'h0, b_rerr}, 128'h4);
    chk("b_hi_addr_valid", {124'h0, b_rvalid}, 128'h4);

    repeat (4) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
